// File: rtl/mult_div_seq.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mult_div_seq
//   Multicycle multiply/divide sequencer. Runs signed or unsigned MULT/DIV on
//   two WIDTH-bit operands using one shift-add (multiply) or restoring
//   shift-subtract (divide) step per cycle. A final FIX cycle applies sign
//   correction and writes the HI/LO pair, after which done pulses for one
//   cycle. A divide with a zero divisor is refused up front with a div0 pulse.
//
//   Ports
//     clock  in   1      rising-edge clock
//     reset  in   1      asynchronous, active-high; clears all state/outputs
//     start  in   1      request, sampled only in IDLE or DONE
//     op     in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//     abort  in   1      synchronous cancel while busy (RUN/FIX)
//     a      in   WIDTH  multiplicand / dividend, latched on accepted start
//     b      in   WIDTH  multiplier / divisor, latched on accepted start
//     busy   out  1      high in RUN and FIX
//     done   out  1      one-cycle pulse; hi/lo valid in the same cycle
//     div0   out  1      one-cycle pulse; divide requested with b == 0
//     hi     out  WIDTH  MULT: upper product, DIV: remainder
//     lo     out  WIDTH  MULT: lower product, DIV: quotient
// -----------------------------------------------------------------------------
module mult_div_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;

    // Iteration state. acc holds the running upper product (multiply) or
    // partial remainder (divide); mq holds the multiplier bits being shifted
    // out (multiply) or the dividend bits shifting out / quotient bits
    // shifting in (divide); dsr is the multiplicand or divisor magnitude.
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   mq;
    logic [WIDTH-1:0]   dsr;
    logic               is_div;
    logic               neg_q;   // negate product / quotient in FIX
    logic               neg_r;   // negate remainder in FIX (dividend sign)

    // Request decode
    logic               accept;
    logic               req_div;
    logic               req_signed;
    logic               div_zero;
    logic               load;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    // One iteration step
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   acc_step;
    logic [WIDTH-1:0]   mq_step;

    // Sign-corrected results
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    // -------------------------------------------------------------------------
    // Request decode. A start is only looked at when the sequencer is free,
    // which is what makes a start while busy harmless.
    // -------------------------------------------------------------------------
    assign accept     = start && ((state == IDLE) || (state == DONE));
    assign req_div    = op[1];
    assign req_signed = ~op[0];
    assign div_zero   = accept && req_div && (b == '0);
    assign load       = accept && !div_zero;

    assign a_neg = req_signed && a[WIDTH-1];
    assign b_neg = req_signed && b[WIDTH-1];
    // MIN_INT negates to itself, which is still the right unsigned magnitude.
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // -------------------------------------------------------------------------
    // Next-state and status outputs
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned and no latch is inferred.
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE, DONE: begin
                done      = (state == DONE);
                // abort has no effect here, so a simultaneous start wins.
                state_nxt = load ? RUN : IDLE;
            end
            RUN: begin
                busy = 1'b1;
                if (abort)
                    state_nxt = IDLE;
                else if (cnt == CNT_W'(1))
                    state_nxt = FIX;
            end
            FIX: begin
                busy      = 1'b1;
                state_nxt = abort ? IDLE : DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // One datapath step.
    //   Multiply: add dsr to acc when the current multiplier bit is set, then
    //   shift {carry, acc, mq} right by one.
    //   Divide: shift {acc, mq} left by one, try subtracting dsr from the
    //   partial remainder and keep the difference only if it did not borrow;
    //   the inverted borrow becomes the new quotient bit.
    // -------------------------------------------------------------------------
    always_comb begin
        sum     = {1'b0, acc} + (mq[0] ? {1'b0, dsr} : '0);
        shifted = {acc, mq[WIDTH-1]};
        trial   = shifted - {1'b0, dsr};
        if (is_div) begin
            acc_step = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
            mq_step  = {mq[WIDTH-2:0], ~trial[WIDTH]};
        end else begin
            acc_step = sum[WIDTH:1];
            mq_step  = {sum[0], mq[WIDTH-1:1]};
        end
    end

    // Sign correction applied on the FIX cycle. The remainder follows the
    // dividend sign, giving truncating division.
    assign prod     = {acc, mq};
    assign prod_fix = neg_q ? -prod : prod;
    assign quot     = neg_q ? -mq : mq;
    assign rem      = neg_r ? -acc : acc;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            mq     <= '0;
            dsr    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            div0   <= 1'b0;
        end else begin
            state <= state_nxt;
            div0  <= div_zero;

            if (load) begin
                acc    <= '0;
                mq     <= a_mag;
                dsr    <= b_mag;
                cnt    <= CNT_W'(WIDTH);
                is_div <= req_div;
                neg_q  <= a_neg ^ b_neg;
                neg_r  <= a_neg;
            end else if (state == RUN && !abort) begin
                acc <= acc_step;
                mq  <= mq_step;
                cnt <= cnt - CNT_W'(1);
            end

            // hi/lo move only on the FIX->DONE transition.
            if (state == FIX && !abort) begin
                if (is_div) begin
                    hi <= rem;
                    lo <= quot;
                end else begin
                    hi <= prod_fix[2*WIDTH-1:WIDTH];
                    lo <= prod_fix[WIDTH-1:0];
                end
            end
        end
    end

endmodule
